// File: rtl/icache_dm_fill.sv
// icache_dm_fill: direct-mapped instruction cache with an integrated
// block-fill controller. Lookup is purely combinational; a miss in IDLE
// launches a fill that issues one word request per cycle and accepts the
// in-order responses one word per cycle until the line is complete.
//
// Optional feature macro: ICACHE_PERF_CNT_EN
//   defined   -> saturating 16-bit hit and miss counters are built.
//   undefined -> hit_cnt / miss_cnt are tied to zero (ports unchanged).
//
// Words are 16 bits (2 bytes), so DATA_W must stay at 16 and bit 0 of the
// fetch address is never used.

module icache_dm_fill #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int NUM_BLOCKS      = 128,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_hit,
    output logic              miss,
    input  logic              inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int CNT_W = OFF_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t state;

    // Lookup address fields.
    logic [OFF_W-1:0] lk_off;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             unused_addr_bit;

    assign lk_off          = fetch_addr[OFF_W:1];
    assign lk_idx          = fetch_addr[OFF_W+IDX_W:OFF_W+1];
    assign lk_tag          = fetch_addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign unused_addr_bit = fetch_addr[0];

    // Line storage. Only the valid bits are reset; tag and data contents are
    // meaningless until their valid bit is set by a completed fill.
    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
    logic [DATA_W-1:0]     data_arr [NUM_BLOCKS][WORDS_PER_BLOCK];

    // Fill bookkeeping, captured when a fill starts.
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] req_next;
    logic             inv_pend;

    // Lookup and fill control terms.
    logic tag_match;
    logic start_fill;
    logic rx_write;
    logic rx_last;

    assign tag_match  = (tag_arr[lk_idx] == lk_tag);
    assign fetch_hit  = fetch_req & valid[lk_idx] & tag_match & (state == IDLE);
    assign miss       = fetch_req & ~fetch_hit;
    assign fetch_data = data_arr[lk_idx][lk_off];

    // An invalidate in the same IDLE cycle as a miss suppresses the fill.
    assign start_fill = (state == IDLE) & miss & ~inv;
    assign rx_write   = (state == FILL) & mem_rvalid;
    assign rx_last    = rx_write & (rx_cnt == LAST_WORD);
    assign req_next   = req_cnt + CNT_ONE;

    // Fill FSM: owns the valid bits, the request stream and the pending-invalidate flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            inv_pend <= 1'b0;
            req_cnt  <= '0;
            rx_cnt   <= '0;
            fill_idx <= '0;
            fill_tag <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inv) begin
                        valid <= '0;
                    end else if (start_fill) begin
                        valid[lk_idx] <= 1'b0;
                        fill_idx      <= lk_idx;
                        fill_tag      <= lk_tag;
                        req_cnt       <= '0;
                        rx_cnt        <= '0;
                        inv_pend      <= 1'b0;
                        mem_req       <= 1'b1;
                        mem_addr      <= {lk_tag, lk_idx, {OFF_W{1'b0}}, 1'b0};
                        state         <= FILL;
                    end
                end

                FILL: begin
                    if (mem_req) begin
                        req_cnt <= req_next;
                        if (req_next < NUM_WORDS) begin
                            mem_addr <= {fill_tag, fill_idx, req_next[OFF_W-1:0], 1'b0};
                        end else begin
                            mem_req <= 1'b0;
                        end
                    end

                    if (inv) begin
                        inv_pend <= 1'b1;
                    end

                    if (rx_write) begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end

                    if (rx_last) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        inv_pend <= 1'b0;
                        if (inv_pend || inv) begin
                            valid <= '0;
                        end else begin
                            valid[fill_idx] <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line data and tag capture from the memory response stream.
    always_ff @(posedge clk) begin
        if (!rst && rx_write) begin
            data_arr[fill_idx][rx_cnt[OFF_W-1:0]] <= mem_rdata;
            if (rx_cnt == LAST_WORD) begin
                tag_arr[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating performance counters: hits per hit cycle, misses per fill start.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (fetch_hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (start_fill && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
